// File: rtl/delta_spike_ctrl.sv
// delta_spike_ctrl
//   Sequencing controller for a delta-modulation spike comparator. Each
//   accepted sample is compared against the stored previous level using a
//   programmable threshold. ON or OFF spike events are emitted over a
//   valid/ready handshake. An optional refractory period can follow each
//   delivered spike.
//
//   Optional feature macro: DELTA_REFRACT_EN
//     defined   -> REFR state, refractory counter and refractory-length
//                  register (cfg addr 2) are built.
//     undefined -> cfg addr 2 writes are ignored, and EMIT returns straight
//                  to IDLE.
//
//   Ports
//     clk, rst_n    clock and asynchronous active-low reset
//     cfg_we        config write strobe
//     cfg_addr      config address:
//                     0 = threshold
//                     1 = control (bit0 enable, bit1 off_en)
//                     2 = refractory length
//                     3 = prev preload (also sets primed)
//     cfg_data      config write data; low bits used
//     in_valid      sample offered
//     in_ready      sample accepted this cycle when in_valid is high
//     in_data       sample
//     spike_valid   spike event pending
//     spike_ready   consumer accepts the pending event
//     spike         event code: 01 = ON, 11 = OFF, 00 = none
//     busy          controller is in any state other than IDLE
module delta_spike_ctrl #(
    parameter int WIDTH  = 5,
    parameter int REFR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [7:0]       cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             spike_valid,
    input  logic             spike_ready,
    output logic [1:0]       spike,
    output logic             busy
);

`ifdef DELTA_REFRACT_EN
    typedef enum logic [1:0] {IDLE, CMP, EMIT, REFR} state_t;
`else
    typedef enum logic [1:0] {IDLE, CMP, EMIT} state_t;
`endif

    state_t             state;
    logic [WIDTH-1:0]   thr;
    logic               enable;
    logic               off_en;
    logic [WIDTH-1:0]   prev;
    logic               primed;
    logic [WIDTH-1:0]   sample;
`ifdef DELTA_REFRACT_EN
    logic [REFR_W-1:0]  refr_len;
    logic [REFR_W-1:0]  refr_cnt;
`endif

    // Only the low bits of cfg_data are meaningful.
    logic cfg_data_unused;
    assign cfg_data_unused = ^cfg_data;

    // The two extra bits hold the sign of the difference and the negated
    // threshold, so every comparison is exact over the full unsigned range.
    logic signed [WIDTH+1:0] delta;
    logic signed [WIDTH+1:0] thr_s;
    logic                    over_pos;
    logic                    under_neg;

    always_comb begin
        delta     = $signed({2'b00, sample}) - $signed({2'b00, prev});
        thr_s     = $signed({2'b00, thr});
        over_pos  = (delta > thr_s);
        under_neg = (delta < -thr_s);
    end

    assign in_ready = (state == IDLE) && enable;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            thr         <= WIDTH'(4);
            enable      <= 1'b0;
            off_en      <= 1'b0;
            prev        <= '0;
            primed      <= 1'b0;
            sample      <= '0;
            spike_valid <= 1'b0;
            spike       <= '0;
`ifdef DELTA_REFRACT_EN
            refr_len    <= '0;
            refr_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && enable) begin
                        sample <= in_data;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    if (!primed) begin
                        prev   <= sample;
                        primed <= 1'b1;
                        state  <= IDLE;
                    end else if (over_pos) begin
                        prev        <= sample;
                        spike       <= 2'b01;
                        spike_valid <= 1'b1;
                        state       <= EMIT;
                    end else if (under_neg) begin
                        prev <= sample;
                        if (off_en) begin
                            spike       <= 2'b11;
                            spike_valid <= 1'b1;
                            state       <= EMIT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                EMIT: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                        spike       <= '0;
`ifdef DELTA_REFRACT_EN
                        if (refr_len != '0) begin
                            refr_cnt <= refr_len;
                            state    <= REFR;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef DELTA_REFRACT_EN
                REFR: begin
                    // Leaving on count 1 gives exactly refr_len cycles in REFR.
                    if (refr_cnt <= REFR_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        refr_cnt <= refr_cnt - REFR_W'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase

            // Config writes come after the FSM so that they override any
            // same-cycle update of prev, state or the spike outputs.
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: thr <= cfg_data[WIDTH-1:0];
                    2'd1: begin
                        enable <= cfg_data[0];
                        off_en <= cfg_data[1];
                        if (!cfg_data[0]) begin
                            state       <= IDLE;
                            primed      <= 1'b0;
                            spike_valid <= 1'b0;
                            spike       <= '0;
                        end
                    end
                    2'd2: begin
`ifdef DELTA_REFRACT_EN
                        refr_len <= cfg_data[REFR_W-1:0];
`endif
                    end
                    default: begin
                        prev   <= cfg_data[WIDTH-1:0];
                        primed <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delta_spike_ctrl.sv
// Directed testbench for delta_spike_ctrl. Expected spike codes are queued by
// the stimulus process and checked by an independent monitor at each
// delivered event. Cycle-level timing checks are done inline.
module tb_delta_spike_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic       spike_valid;
    logic       spike_ready;
    logic [1:0] spike;
    logic       busy;

    int vectors    = 0;
    int miscompares = 0;
    logic [1:0] exp_q[$];

    delta_spike_ctrl #(.WIDTH(5), .REFR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spike       (spike),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Returns in the cycle after the accepting edge (the CMP cycle).
    task automatic send(input logic [4:0] d);
        bit accepted = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                accepted = 1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        check("in_accept", int'(accepted), 1);
    endtask

    // Sample that must not produce an event; returns in cycle N+2.
    task automatic send_quiet(input logic [4:0] d);
        send(d);
        tick();
        check("quiet_no_spike", int'(spike_valid), 0);
    endtask

    // Sample that must produce an event visible in cycle N+2; with
    // spike_ready high it is consumed there and we return in cycle M+1.
    task automatic send_spike(input logic [4:0] d, input logic [1:0] code);
        exp_q.push_back(code);
        send(d);
        check("cmp_cycle_no_valid", int'(spike_valid), 0);
        tick();
        check("spike_latency", int'(spike_valid), 1);
        if (spike_ready) tick();
    endtask

    // Scoreboard monitor: one pop per delivered event.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && spike_valid === 1'b1 && spike_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_spike: got %0d expected none at %0t", spike, $time);
                end else begin
                    check("spike_code", int'(spike), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        spike_ready = 1'b1;
        #3;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_spike_valid", int'(spike_valid), 0);
        check("rst_spike", int'(spike), 0);
        check("rst_busy", int'(busy), 0);
        #9 rst_n = 1'b1;
        tick();
        check("disabled_in_ready", int'(in_ready), 0);

        // Priming: enable with default thr = 4.
        cfg_write(2'd1, 8'h01);
        check("enabled_in_ready", int'(in_ready), 1);
        send(5'd10);
        check("cmp_busy", int'(busy), 1);
        check("cmp_in_ready", int'(in_ready), 0);
        tick();
        check("prime_no_spike", int'(spike_valid), 0);
        check("prime_next_ready", int'(in_ready), 1);
        send_spike(5'd15, 2'b01);
        check("post_spike_ready", int'(in_ready), 1);
        check("post_spike_code", int'(spike), 0);

        // Equality boundary: |delta| == thr gives no event, prev stays 15.
        send_quiet(5'd19);
        send_quiet(5'd11);
        send_quiet(5'd16);
        send_spike(5'd20, 2'b01);

        // OFF gating.
        cfg_write(2'd3, 8'd15);
        send_quiet(5'd5);
        cfg_write(2'd1, 8'h03);
        send_quiet(5'd9);
        send_spike(5'd0, 2'b11);

        // Back-pressure: six cycles with spike_ready low.
        spike_ready = 1'b0;
        exp_q.push_back(2'b01);
        send(5'd10);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("bp_valid", int'(spike_valid), 1);
            check("bp_code", int'(spike), 1);
            check("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        spike_ready = 1'b1;
        check("bp_still_valid", int'(spike_valid), 1);
        tick();
        check("bp_released", int'(spike_valid), 0);

        // Refractory period of 3 cycles after the handshake.
        cfg_write(2'd2, 8'd3);
        send_spike(5'd20, 2'b01);
`ifdef DELTA_REFRACT_EN
        for (int i = 0; i < 3; i++) begin
            check("refr_in_ready_low", int'(in_ready), 0);
            check("refr_busy", int'(busy), 1);
            tick();
        end
        check("refr_in_ready_high", int'(in_ready), 1);
`else
        check("norefr_in_ready", int'(in_ready), 1);
`endif
        cfg_write(2'd2, 8'd0);

        // Abort in EMIT.
        spike_ready = 1'b0;
        send(5'd30);
        tick();
        check("abort_pre_valid", int'(spike_valid), 1);
        cfg_write(2'd1, 8'h00);
        check("abort_valid", int'(spike_valid), 0);
        check("abort_spike", int'(spike), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        spike_ready = 1'b1;
        cfg_write(2'd1, 8'h03);
        send_quiet(5'd5);
        send_spike(5'd31, 2'b01);

        for (int i = 0; i < 4; i++) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/delta_spike_ctrl.md
# delta_spike_ctrl

Sequencing controller for the delta-modulation spike comparator. It accepts samples over a valid/ready handshake and holds the previous-level register. It compares each sample against that level with a programmable threshold and emits ON/OFF spike events over a second handshake. An optional refractory period follows each emitted spike. It sits between the sample source (ADC/input pins) and the spike output pins, and its threshold, control and refractory registers are written over a small config port.

## Interface
- `WIDTH`, 5, sample, previous-level and threshold width (unsigned).
- `REFR_W`, 4, refractory counter width.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cfg_we` input 1: config write strobe.
- `cfg_addr` input 2: 0 = threshold, 1 = control (bit0 enable, bit1 off_en), 2 = refractory length, 3 = prev preload.
- `cfg_data` input 8: write data; low bits used, upper bits ignored.
- `in_valid` input 1: sample offered.
- `in_ready` output 1: controller can accept a sample.
- `in_data` input WIDTH: sample.
- `spike_valid` output 1: spike event pending.
- `spike_ready` input 1: consumer accepts event.
- `spike` output 2: [1] = OFF, [0] = any spike; 01 = ON, 11 = OFF, 00 = none.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Registers and reset values:
  - thr = 4, enable = 0, off_en = 0, refr_len = 0.
  - prev = 0, primed = 0.
- Outputs at reset: in_ready = 0, spike_valid = 0, spike = 00, busy = 0.
- States: IDLE, CMP, EMIT, REFR.
- IDLE:
  - in_ready = enable.
  - A handshake (in_valid & in_ready) latches in_data into the sample register and moves to CMP.
- CMP (one cycle):
  - If primed = 0: prev <= sample, primed <= 1, go to IDLE. No event.
  - Otherwise delta = sample − prev, computed as a WIDTH+1-bit signed value (range −31..+31 at default width).
  - Compare delta against +thr and −thr with thr zero-extended; all comparisons signed, WIDTH+2 bits.
  - delta > thr: prev <= sample, spike <= 01, go to EMIT.
  - delta < −thr: prev <= sample.
    - If off_en = 1: spike <= 11, go to EMIT.
    - If off_en = 0: go to IDLE, no event.
  - Otherwise (|delta| <= thr, including equality): prev unchanged, go to IDLE.
- EMIT:
  - spike_valid = 1; spike is held stable until spike_ready.
  - On handshake: go to REFR if the refractory feature is present and refr_len ≠ 0, else go to IDLE.
  - spike returns to 00 after the handshake.
- REFR:
  - Counter loads refr_len on entry and decrements each cycle.
  - Exit to IDLE when the counter reaches 1, giving exactly refr_len cycles with in_ready = 0.
- Config writes:
  - A write takes effect on the edge where cfg_we is high.
  - A CMP in the same cycle uses the pre-write value.
  - Addr 3 sets prev = cfg_data[WIDTH-1:0] and primed = 1.
  - If CMP writes prev in the same cycle, the config write wins.
- Enable cleared (write to addr 1 with bit0 = 0) in any state:
  - Next state is IDLE and primed <= 0.
  - A pending spike is dropped: spike_valid falls next cycle, spike = 00.
  - The refractory count is abandoned.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous).

## Timing
- Sample accepted at edge N; CMP occupies cycle N+1.
- spike_valid rises after edge N+1, i.e. visible in cycle N+2.
- Earliest next in_ready:
  - No spike: cycle N+2.
  - Spike consumed at edge M with no refractory: cycle M+1.
  - With refractory: cycle M+1+refr_len.
- Throughput without spikes: one sample per 2 cycles.
- spike_valid and spike are registered outputs; in_ready and busy are decoded from registered state only.

## Configuration
- `DELTA_REFRACT_EN` defined:
  - REFR state, refractory counter and the addr 2 register are built.
  - refr_len = 0 still means no refractory period.
- `DELTA_REFRACT_EN` undefined:
  - No REFR state and no counter.
  - Addr 2 writes are ignored.
  - EMIT always returns to IDLE after the handshake.

## Test plan
- Priming:
  - Stimulus: reset, enable = 1, thr = 4, send 10, then 15.
  - Response: first sample gives no event; second gives spike = 01 in cycle N+2; prev = 15.
- Equality boundary:
  - Stimulus: prev = 15, send 19, then 11.
  - Response: no events (|delta| = 4 = thr); prev stays 15.
- OFF gating:
  - Stimulus: off_en = 0, send 5 after prev = 15.
  - Response: no event and prev = 5. Then off_en = 1, send 0 → spike = 11.
- Back-pressure:
  - Stimulus: spike pending with spike_ready held low 6 cycles.
  - Response: spike_valid and spike stable for all 6 cycles; in_ready = 0 throughout; one event delivered.
- Refractory (macro defined):
  - Stimulus: refr_len = 3; spike consumed at edge M.
  - Response: in_ready low in cycles M+1..M+3, high in M+4. With the macro undefined, in_ready is high in M+1.
- Abort:
  - Stimulus: write enable = 0 while in EMIT.
  - Response: spike_valid low next cycle, busy = 0, primed cleared. After re-enable, the next sample produces no event.
